mul_div_unit: RTL and testbench

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

---
 rtl/mul_div_unit_if.sv | 25 ++
 rtl/mul_div_unit.sv | 147 ++++++++++++++
 tb/tb_mul_div_unit.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/mul_div_unit_if.sv
// Request/response bundle for the iterative RV32M multiply/divide unit.
// The requester (master) drives the operation and consumes the result;
// the unit (slave) accepts requests and presents results.
interface mul_div_unit_if #(
    parameter int WIDTH = 32
) ();
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       funct3;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;

    modport master (
        output in_valid, funct3, A, B, out_ready,
        input  in_ready, out_valid, result
    );

    modport slave (
        input  in_valid, funct3, A, B, out_ready,
        output in_ready, out_valid, result
    );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit.
// Works on operand magnitudes, one radix-2 step per cycle (shift-add for
// multiply, restoring subtract-shift for divide), then applies the sign in a
// single fix-up cycle. Divide-by-zero and signed overflow bypass the iteration.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input logic            clk,
    input logic            rst_n,
    mul_div_unit_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_REM    = 3'b110;

    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [2:0]       op;
    logic             neg_q;    // final product / quotient is negative
    logic             neg_r;    // final remainder is negative (follows dividend)
    logic [WIDTH-1:0] hi;       // product high half / partial remainder
    logic [WIDTH-1:0] lo;       // multiplier / dividend shifting into quotient
    logic [WIDTH-1:0] dsr;      // multiplicand / divisor magnitude
    logic [WIDTH-1:0] res;

    logic             accept;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             special;
    logic [WIDTH-1:0] special_res;
    logic [WIDTH-1:0] step_hi, step_lo;
    logic [WIDTH-1:0] fix_res;

    assign accept        = bus.in_valid && (state == IDLE);
    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.result    = res;

    // Operand decode: signedness, magnitudes and the bypass cases.
    always_comb begin
        a_neg = (bus.funct3 inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM}) && bus.A[WIDTH-1];
        b_neg = (bus.funct3 inside {OP_MULH, OP_DIV, OP_REM}) && bus.B[WIDTH-1];
        a_mag = a_neg ? -bus.A : bus.A;
        b_mag = b_neg ? -bus.B : bus.B;
        special     = 1'b0;
        special_res = '0;
        if (bus.funct3[2] && (bus.B == '0)) begin
            special     = 1'b1;
            special_res = bus.funct3[1] ? bus.A : '1;
        end else if ((bus.funct3 == OP_DIV || bus.funct3 == OP_REM) &&
                     (bus.A == MIN_NEG) && (bus.B == '1)) begin
            special     = 1'b1;
            special_res = bus.funct3[1] ? '0 : MIN_NEG;
        end
    end

    // One iteration step and the sign fix-up of the finished magnitudes.
    always_comb begin
        logic [WIDTH:0]     mul_sum;
        logic [WIDTH:0]     div_sh;
        logic [2*WIDTH-1:0] prod;
        logic [WIDTH-1:0]   quo, rem;
        mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, dsr} : '0);
        div_sh  = {hi, lo[WIDTH-1]};
        step_hi = mul_sum[WIDTH:1];
        step_lo = {mul_sum[0], lo[WIDTH-1:1]};
        if (op[2]) begin
            // Remainder stays below the divisor, so the subtraction fits WIDTH bits.
            if (div_sh >= {1'b0, dsr}) begin
                step_hi = div_sh[WIDTH-1:0] - dsr;
                step_lo = {lo[WIDTH-2:0], 1'b1};
            end else begin
                step_hi = div_sh[WIDTH-1:0];
                step_lo = {lo[WIDTH-2:0], 1'b0};
            end
        end
        prod = neg_q ? -{hi, lo} : {hi, lo};
        quo  = neg_q ? -lo : lo;
        rem  = neg_r ? -hi : hi;
        if (op[2])
            fix_res = op[1] ? rem : quo;
        else
            fix_res = (op == OP_MUL) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = special ? DONE : CALC;
            CALC: if (cnt == '0) state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: latch operands on accept, iterate in CALC, publish the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            op    <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            hi    <= '0;
            lo    <= '0;
            dsr   <= '0;
            res   <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    op    <= bus.funct3;
                    neg_q <= a_neg ^ b_neg;
                    neg_r <= a_neg;
                    hi    <= '0;
                    lo    <= a_mag;
                    dsr   <= b_mag;
                    cnt   <= CW'(WIDTH - 1);
                    if (special) res <= special_res;
                end
                CALC: begin
                    hi  <= step_hi;
                    lo  <= step_lo;
                    cnt <= cnt - 1'b1;
                end
                FIX: res <= fix_res;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mul_div_unit.sv
// Directed and random self-checking bench for mul_div_unit.
module tb_mul_div_unit;
    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;
    int   accepts = 0;
    int   results = 0;

    always #5 clk = ~clk;

    mul_div_unit_if #(.WIDTH(32)) bus ();

    mul_div_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Handshake monitor: counts accepted requests and consumed results.
    always @(posedge clk) begin
        if (rst_n) begin
            if (bus.in_valid && bus.in_ready) accepts++;
            if (bus.out_valid && bus.out_ready) results++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] golden(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint     sa, sb, ua, ub;
        logic [63:0] p;
        int         ia, ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        ia = $signed(a);
        ib = $signed(b);
        case (f)
            3'd0: begin p = 64'(ua * ub); return p[31:0]; end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = 64'(ua * ub); return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
                return 32'(ia / ib);
            end
            3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
                return 32'(ia % ib);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Issue one op, check result and latency, optionally stall, then consume.
    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_edge,
                          input int stall);
        int k;
        logic [31:0] held;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.funct3   = f;
        bus.A        = a;
        bus.B        = b;
        k = 0;
        while (!bus.in_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_accept"}, 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        k = 0;
        do begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                bus.in_valid = 1'b0;
                bus.funct3   = 3'($urandom);
                bus.A        = $urandom;
                bus.B        = $urandom;
            end
        end while (!bus.out_valid && k < 100);
        check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        if (exp_edge != 0) check({tag, "_edge"}, 32'(k), 32'(exp_edge));
        check(tag, bus.result, exp);
        held = bus.result;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check({tag, "_hold_res"}, bus.result, held);
            check({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
            check({tag, "_hold_inrdy"}, 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({tag, "_consumed"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_idle"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        int a0, r0, seen;
        logic [2:0]  f;
        logic [31:0] a, b;
        bit          sp;

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.funct3    = '0;
        bus.A         = '0;
        bus.B         = '0;
        #1;
        check("rst_inrdy", 32'(bus.in_ready), 32'd1);
        check("rst_outvalid", 32'(bus.out_valid), 32'd0);
        check("rst_result", bus.result, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_no_req", 32'(bus.in_ready), 32'd1);

        // Multiplies
        run_op("mul_7_m3",   3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34, 0);
        run_op("mulhu_max",  3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34, 0);
        run_op("mulh_min",   3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 34, 0);
        run_op("mulhsu_m1",  3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34, 0);
        // Divides
        run_op("div_m7_2",   3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34, 0);
        run_op("rem_m7_2",   3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34, 0);
        run_op("divu_100_7", 3'd5, 32'd100,      32'd7,        32'd14,       34, 0);
        run_op("remu_100_7", 3'd7, 32'd100,      32'd7,        32'd2,        34, 0);
        // Bypass cases
        run_op("divu_by0",   3'd5, 32'd5,        32'd0,        32'hFFFFFFFF, 1, 0);
        run_op("remu_by0",   3'd7, 32'd5,        32'd0,        32'd5,        1, 0);
        run_op("div_by0",    3'd4, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF, 1, 0);
        run_op("div_ovf",    3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 0);
        run_op("rem_ovf",    3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1, 0);
        // Output back-pressure
        run_op("stall",      3'd5, 32'd1000,     32'd3,        32'd333,      34, 10);

        // Reset in the middle of CALC aborts the operation
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.funct3   = 3'd0;
        bus.A        = 32'd123;
        bus.B        = 32'd456;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (14) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_outvalid", 32'(bus.out_valid), 32'd0);
        check("abort_inrdy", 32'(bus.in_ready), 32'd1);
        check("abort_result", bus.result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1;
        end
        check("abort_no_result", 32'(seen), 32'd0);
        run_op("after_abort", 3'd0, 32'd123, 32'd456, 32'd56088, 34, 0);

        // Random back-to-back traffic against the reference model
        a0 = accepts;
        r0 = results;
        for (int n = 0; n < 1000; n++) begin
            f = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 9))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 20));
                2: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
                3: b = 32'($signed(-$urandom_range(1, 20)));
                default: ;
            endcase
            sp = f[2] && (b == 0 || (!f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_op("rand", f, a, b, golden(f, a, b), sp ? 1 : 34, $urandom_range(0, 3));
        end
        check("rand_accepts", 32'(accepts - a0), 32'd1000);
        check("rand_results", 32'(results - r0), 32'd1000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
